program_loader_ctrl: RTL and testbench
======================================

Name: program_loader_ctrl

Overview:
- Sequences the byte-wide program memory and the CPU core through load, run and halt phases.
- A host streams a framed program image over a valid/ready byte interface. The block writes the image into memory and checks it against an 8-bit checksum.
- On a good checksum it releases CPU reset. It then watches the CPU PC for a branch-to-self halt and returns the memory port and CPU to a frozen state.
- It owns the memory-port select between the loader path and the CPU path.

Parameters:
ADDR_W, 10, width of memory byte address.
MEM_DEPTH, 1024, program memory size in bytes; maximum legal image length.
HALT_WINDOW, 64, consecutive cycles of unchanged cpu_pc that declare a halt (must exceed the CPU's per-instruction cycle count).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high.
load_start  in  1  one-cycle pulse; begin a new load.
stop  in  1  one-cycle pulse; abort the current activity and return to IDLE.
host_valid  in  1  host_byte is valid.
host_ready  out  1  block accepts host_byte this cycle.
host_byte  in  8  frame byte.
mem_sel  out  1  1 = loader drives the memory port; 0 = CPU drives it.
mem_we  out  1  loader write strobe.
mem_addr  out  ADDR_W  loader write address.
mem_wdata  out  8  loader write data.
cpu_reset  out  1  held-reset to the CPU core.
cpu_pc  in  32  CPU PC (even-aligned).
state  out  3  IDLE=0, LEN_LO=1, LEN_HI=2, PAYLOAD=3, CHECK=4, RUN=5, DONE=6, ERROR=7.
err_code  out  2  0 none, 1 length too large, 2 checksum mismatch.
run_cycles  out  32  cycles spent in RUN; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset values:
  - state=IDLE, cpu_reset=1, mem_sel=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - host_ready=0, err_code=0, run_cycles=0.
  - Internal length, count, checksum and halt counter all 0.
- Frame format: len_lo, len_hi (16-bit little-endian length N), then N payload bytes, then one checksum byte.
  - The checksum byte equals the sum of the payload bytes mod 256.
- Handshake: a byte transfers on a cycle with host_valid & host_ready.
  - host_ready is combinational from state: 1 in LEN_LO, LEN_HI, PAYLOAD and CHECK; 0 elsewhere.
  - host_valid gaps stall the FSM with no side effects.
- IDLE:
  - On load_start: clear err_code, address, checksum and run_cycles; go to LEN_LO.
- LEN_LO: on transfer, latch len[7:0] and go to LEN_HI.
- LEN_HI: on transfer, latch len[15:8], then:
  - N > MEM_DEPTH: go to ERROR with err_code=1.
  - N == 0: go to CHECK.
  - Otherwise: go to PAYLOAD.
- PAYLOAD: on each transfer:
  - Register mem_addr=current address, mem_wdata=byte, mem_we=1 for exactly the next cycle (one-cycle write latency).
  - Address increments by 1; checksum += byte (8-bit wrap).
  - The transfer of payload byte N-1 moves the FSM to CHECK.
- CHECK: on transfer, compare the byte against the running checksum.
  - Equal: go to RUN.
  - Not equal: go to ERROR with err_code=2.
  - With N == 0 the expected checksum is 0.
- RUN:
  - Outputs: cpu_reset=0, mem_sel=0.
  - run_cycles increments each RUN cycle, saturating.
  - Halt counter resets to 0 whenever cpu_pc differs from its value on the previous cycle, and increments otherwise.
  - When the halt counter reaches HALT_WINDOW-1, go to DONE.
  - The first RUN cycle always counts as a change.
- DONE and ERROR:
  - cpu_reset=1, mem_sel=1.
  - run_cycles and err_code hold their values.
  - load_start restarts the sequence (same action as in IDLE).
- cpu_reset and mem_sel are registered and switch on the same edge the state changes. The CPU never sees memory while mem_sel=1.
- load_start is ignored in LEN_LO, LEN_HI, PAYLOAD, CHECK and RUN.
- stop in any non-IDLE state:
  - Next state IDLE, cpu_reset=1, mem_sel=1.
  - A transfer occurring in the same cycle is discarded (no write, no count).
  - A mem_we already registered from the previous cycle still completes.
- stop has priority over load_start and over any transfer. reset has priority over everything.
- Address width: ADDR_W bits. The N ≤ MEM_DEPTH check guarantees no wrap.

Test Plan:
1. Good load + run: frame 03 00 AA BB CC 31 (the checksum byte is 0x31 because 0xAA+0xBB+0xCC=0x231, mod 256 = 0x31).
   - Writes land at addresses 0,1,2 with data AA,BB,CC, each mem_we one cycle after its transfer.
   - Then state=RUN and cpu_reset=0 on the cycle after the checksum transfer.
2. Bad checksum: frame 02 00 10 20 31 -> state=ERROR, err_code=2, cpu_reset stays 1. A following load_start returns to LEN_LO with err_code=0.
3. Oversize / empty frames:
   - Length 01 04 (N=1025) -> ERROR with err_code=1 right after LEN_HI; no mem_we pulses.
   - Length 00 00 then checksum 00 -> RUN.
4. Backpressure and stop: host_valid toggles 1/0 during a 4-byte payload -> exactly 4 writes at addresses 0-3.
   - Separately, stop asserted together with the 2nd payload transfer -> only 1 write, state=IDLE next cycle.
5. Halt detection: in RUN, hold cpu_pc=0x20 constant -> DONE after exactly HALT_WINDOW cycles. cpu_pc changing every 7 cycles never reaches DONE.
6. reset asserted mid-PAYLOAD -> all outputs return to reset values on the next edge; a subsequent good frame loads from address 0.

Source files
------------

// File: rtl/program_loader_ctrl.sv
// program_loader_ctrl: loads a framed, checksummed program image into memory, then runs the CPU until it halts.
module program_loader_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int MEM_DEPTH   = 1024,
  parameter int HALT_WINDOW = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              stop,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [7:0]        host_byte,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  input  logic [31:0]       cpu_pc,
  output logic [2:0]        state,
  output logic [1:0]        err_code,
  output logic [31:0]       run_cycles
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, RUN, DONE, ERROR} state_t;
  localparam int HW = $clog2(HALT_WINDOW) + 1;
  localparam logic [16:0] MAX_LEN = 17'(MEM_DEPTH);
  localparam logic [HW-1:0] HALT_LAST = HW'(HALT_WINDOW - 1);
  state_t st;
  logic [15:0] len;
  logic [ADDR_W-1:0] addr;
  logic [7:0] csum;
  logic [HW-1:0] halt_cnt, halt_next;
  logic [31:0] prev_pc;
  logic xfer, last_byte;
  logic [15:0] n_next;
  assign state = st;
  assign host_ready = st inside {LEN_LO, LEN_HI, PAYLOAD, CHECK};
  assign xfer = host_valid & host_ready;
  assign n_next = {host_byte, len[7:0]};
  assign last_byte = 16'(addr) == len - 16'd1;
  // run_cycles is still zero on the first RUN cycle, which forces that cycle to count as a PC change
  assign halt_next = (run_cycles == '0 || cpu_pc != prev_pc) ? '0 : halt_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cpu_reset <= 1'b1;
      mem_sel <= 1'b1;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err_code <= '0;
      run_cycles <= '0;
      len <= '0;
      addr <= '0;
      csum <= '0;
      halt_cnt <= '0;
      prev_pc <= '0;
    end else begin
      mem_we <= 1'b0;
      if (stop && st != IDLE) begin
        st <= IDLE;
        cpu_reset <= 1'b1;
        mem_sel <= 1'b1;
      end else begin
        case (st)
          IDLE, DONE, ERROR: if (load_start) begin
            err_code <= '0;
            addr <= '0;
            csum <= '0;
            run_cycles <= '0;
            st <= LEN_LO;
          end
          LEN_LO: if (xfer) begin
            len[7:0] <= host_byte;
            st <= LEN_HI;
          end
          LEN_HI: if (xfer) begin
            len[15:8] <= host_byte;
            if ({1'b0, n_next} > MAX_LEN) begin
              st <= ERROR;
              err_code <= 2'd1;
            end else begin
              st <= (n_next == '0) ? CHECK : PAYLOAD;
            end
          end
          PAYLOAD: if (xfer) begin
            mem_we <= 1'b1;
            mem_addr <= addr;
            mem_wdata <= host_byte;
            addr <= addr + 1'b1;
            csum <= csum + host_byte;
            if (last_byte) st <= CHECK;
          end
          CHECK: if (xfer) begin
            if (host_byte == csum) begin
              st <= RUN;
              cpu_reset <= 1'b0;
              mem_sel <= 1'b0;
              halt_cnt <= '0;
            end else begin
              st <= ERROR;
              err_code <= 2'd2;
            end
          end
          RUN: begin
            run_cycles <= run_cycles + {31'b0, ~&run_cycles};
            prev_pc <= cpu_pc;
            halt_cnt <= halt_next;
            if (halt_next == HALT_LAST) begin
              st <= DONE;
              cpu_reset <= 1'b1;
              mem_sel <= 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_program_loader_ctrl.sv
// tb_program_loader_ctrl: directed frames; a negedge monitor scores memory writes against a queue of expected writes.
module tb_program_loader_ctrl;
  logic clk = 1'b0, reset = 1'b1, load_start = 1'b0, stop = 1'b0, host_valid = 1'b0;
  logic host_ready, mem_sel, mem_we, cpu_reset;
  logic [7:0] host_byte = '0, mem_wdata;
  logic [9:0] mem_addr;
  logic [31:0] cpu_pc = 32'h20, run_cycles;
  logic [2:0] state;
  logic [1:0] err_code;
  logic [17:0] exp_q[$];
  int checks = 0, errors = 0;

  program_loader_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start), .stop(stop),
    .host_valid(host_valid), .host_ready(host_ready), .host_byte(host_byte),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .state(state), .err_code(err_code),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h/%h required=none", mem_addr, mem_wdata);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e[17:8]));
        chk("write_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge on which the byte transferred.
  task automatic send(input logic [7:0] b);
    int n = 0;
    host_valid = 1'b1;
    host_byte = b;
    while (!host_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!host_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_ready required=ready");
    end else begin
      @(posedge clk); #1;
    end
    host_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [9:0] a, input logic [7:0] b);
    exp_q.push_back({a, b});
    send(b);
  endtask

  task automatic pulse(input bit is_stop);
    if (is_stop) stop = 1'b1; else load_start = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    load_start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_mem_sel", 32'(mem_sel), 1);
    chk("rst_host_ready", 32'(host_ready), 0);
    chk("rst_err", 32'(err_code), 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    // good load, then halt on a constant PC
    pulse(0);
    chk("t1_len_lo", 32'(state), 1);
    send(8'h03); send(8'h00);
    chk("t1_payload", 32'(state), 3);
    send_payload(0, 8'hAA);
    chk("t1_we_next_cycle", 32'(mem_we), 1);
    send_payload(1, 8'hBB);
    send_payload(2, 8'hCC);
    chk("t1_check", 32'(state), 4);
    send(8'h31);
    chk("t1_run", 32'(state), 5);
    chk("t1_cpu_reset", 32'(cpu_reset), 0);
    chk("t1_mem_sel", 32'(mem_sel), 0);
    repeat (63) @(posedge clk);
    #1 chk("t5_still_run", 32'(state), 5);
    @(posedge clk); #1;
    chk("t5_done", 32'(state), 6);
    chk("t5_run_cycles", run_cycles, 64);
    chk("t5_done_cpu_reset", 32'(cpu_reset), 1);
    chk("t5_done_mem_sel", 32'(mem_sel), 1);
    // bad checksum
    pulse(0);
    chk("t2_restart", 32'(state), 1);
    send(8'h02); send(8'h00);
    send_payload(0, 8'h10);
    send_payload(1, 8'h20);
    send(8'h31);
    chk("t2_error", 32'(state), 7);
    chk("t2_err_code", 32'(err_code), 2);
    chk("t2_cpu_reset", 32'(cpu_reset), 1);
    pulse(0);
    chk("t2_reload", 32'(state), 1);
    chk("t2_err_clear", 32'(err_code), 0);
    // oversize then empty frame
    send(8'h01); send(8'h04);
    chk("t3_oversize", 32'(state), 7);
    chk("t3_err_code", 32'(err_code), 1);
    @(posedge clk); #1;
    chk("t3_no_writes", 32'(mem_we), 0);
    pulse(0);
    send(8'h00); send(8'h00);
    chk("t3_empty_check", 32'(state), 4);
    send(8'h00);
    chk("t3_empty_run", 32'(state), 5);
    pulse(1);
    chk("t3_stop_idle", 32'(state), 0);
    chk("t3_stop_cpu_reset", 32'(cpu_reset), 1);
    // backpressure: gap cycle after every payload byte
    pulse(0);
    send(8'h04); send(8'h00);
    for (int i = 0; i < 4; i++) begin
      send_payload(10'(i), 8'(i + 1));
      @(posedge clk); #1;
      chk("t4_gap_state", 32'(state), i == 3 ? 4 : 3);
    end
    send(8'h0A);
    chk("t4_run", 32'(state), 5);
    pulse(1);
    chk("t4_queue_empty", 32'(exp_q.size()), 0);
    // stop on the second payload transfer
    pulse(0);
    send(8'h02); send(8'h00);
    send_payload(0, 8'h55);
    host_valid = 1'b1;
    host_byte = 8'h66;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    host_valid = 1'b0;
    chk("t4_stop_idle", 32'(state), 0);
    chk("t4_stop_no_we", 32'(mem_we), 0);
    // PC changing every 7 cycles never halts
    pulse(0);
    send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 210; i++) begin
      if (i % 7 == 6) cpu_pc = cpu_pc + 32'd2;
      @(posedge clk); #1;
    end
    chk("t5_no_halt", 32'(state), 5);
    chk("t5_run_cycles_210", run_cycles, 210);
    pulse(1);
    cpu_pc = 32'h20;
    // reset in the middle of a payload
    pulse(0);
    send(8'h03); send(8'h00);
    send_payload(0, 8'hAA);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_state", 32'(state), 0);
    chk("t6_mem_we", 32'(mem_we), 0);
    chk("t6_mem_addr", 32'(mem_addr), 0);
    chk("t6_mem_wdata", 32'(mem_wdata), 0);
    chk("t6_cpu_reset", 32'(cpu_reset), 1);
    chk("t6_mem_sel", 32'(mem_sel), 1);
    chk("t6_host_ready", 32'(host_ready), 0);
    pulse(0);
    send(8'h01); send(8'h00);
    send_payload(0, 8'h77);
    send(8'h77);
    chk("t6_run", 32'(state), 5);
    @(posedge clk); #1;
    chk("t6_queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
